serial_paralelo_lane: RTL and testbench

- Per-lane receive deserializer and word aligner that sits directly upstream of the unstriping stage. It feeds that stage's lane_N/valid_N inputs, one instance per lane.
- Takes a 1-bit serial stream, MSB first, produced by the transmit parallel-to-serial stage. It finds 32-bit word boundaries by hunting for the idle word, locks after LOCK_COUNT consecutive aligned idles, then emits 32-bit words with a valid flag.
- Idle words are never presented as valid data.

---
 rtl/serial_paralelo_lane.sv | 124 ++++++++++++
 tb/tb_serial_paralelo_lane.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/serial_paralelo_lane.sv
// serial_paralelo_lane: per-lane receive deserializer and word aligner.
// Shifts in a MSB-first serial stream, hunts for the idle word to find
// word boundaries, locks after LOCK_COUNT consecutive aligned idles and
// then presents each received non-idle word on lane_out with valid_out.
module serial_paralelo_lane #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] IDLE_WORD  = 32'hBCBC0000,
  parameter int               LOCK_COUNT = 4
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] lane_out,
  output logic             valid_out,
  output logic             word_strobe,
  output logic             active
);

  // Bit counter spans one word; idle counter must be able to hold LOCK_COUNT.
  localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ICW = $clog2(LOCK_COUNT + 1) > 0 ? $clog2(LOCK_COUNT + 1) : 1;

  localparam logic [CW-1:0]  LAST_BIT   = CW'(WIDTH - 1);
  localparam logic [ICW:0]   LOCK_LIMIT = (ICW + 1)'(LOCK_COUNT);
  localparam logic [ICW-1:0] IDLE_SAT   = ICW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    bit_cnt;
  logic [ICW-1:0]   idle_cnt;

  logic [WIDTH-1:0] win;
  logic             win_is_idle;
  logic             at_boundary;
  logic [ICW:0]     idle_cnt_inc;

  // The window includes the bit being sampled this edge, so a match is seen
  // on the very edge that captures the word's LSB.
  assign win          = {sr[WIDTH-2:0], data_in};
  assign win_is_idle  = (win == IDLE_WORD);
  assign at_boundary  = (bit_cnt == LAST_BIT);
  assign idle_cnt_inc = {1'b0, idle_cnt} + {{ICW{1'b0}}, 1'b1};

  // Serial-to-parallel shift register, MSB first.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      sr <= '0;
    end else begin
      sr <= win;
    end
  end

  // Alignment FSM with registered lane outputs.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state       <= SEARCH;
      bit_cnt     <= '0;
      idle_cnt    <= '0;
      lane_out    <= '0;
      valid_out   <= 1'b0;
      word_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      // Strobe is a single-cycle pulse; only a boundary in ACTIVE re-raises it.
      word_strobe <= 1'b0;

      unique case (state)
        SEARCH: begin
          // Bit-slip hunt: any bit position may start a word.
          bit_cnt <= '0;
          if (win_is_idle) begin
            state    <= LOCKING;
            idle_cnt <= ICW'(1);
          end
        end

        LOCKING: begin
          bit_cnt <= bit_cnt + CW'(1);
          if (at_boundary) begin
            if (!win_is_idle) begin
              // Boundary guess was wrong (or data arrived early): re-hunt.
              state    <= SEARCH;
              idle_cnt <= '0;
            end else if (idle_cnt_inc >= LOCK_LIMIT) begin
              // Enough consecutive aligned idles: declare lock.
              state    <= ACTIVE;
              idle_cnt <= IDLE_SAT;
              active   <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt_inc[ICW-1:0];
            end
          end
        end

        ACTIVE: begin
          bit_cnt <= bit_cnt + CW'(1);
          if (at_boundary) begin
            word_strobe <= 1'b1;
            if (win_is_idle) begin
              // Idle is never presented as data; keep the last data word.
              valid_out <= 1'b0;
            end else begin
              lane_out  <= win;
              valid_out <= 1'b1;
            end
          end
        end

        default: begin
          state    <= SEARCH;
          bit_cnt  <= '0;
          idle_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_paralelo_lane.sv
// tb_serial_paralelo_lane: directed bench for the lane deserializer/aligner.
module tb_serial_paralelo_lane;

  localparam int          WIDTH = 32;
  localparam logic [31:0] IDLE  = 32'hBCBC0000;

  logic             clk_32f = 1'b0;
  logic             reset   = 1'b1;
  logic             data_in = 1'b0;
  logic [WIDTH-1:0] lane_out;
  logic             valid_out;
  logic             word_strobe;
  logic             active;

  int n_cmp = 0;
  int n_err = 0;

  serial_paralelo_lane #(
    .WIDTH(WIDTH),
    .IDLE_WORD(IDLE),
    .LOCK_COUNT(4)
  ) dut (
    .clk_32f(clk_32f),
    .reset(reset),
    .data_in(data_in),
    .lane_out(lane_out),
    .valid_out(valid_out),
    .word_strobe(word_strobe),
    .active(active)
  );

  always #5 clk_32f = ~clk_32f;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one bit, let the rising edge sample it, then settle past the edge.
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  // Send one word MSB first and check the outputs around its LSB edge.
  task automatic send_word(input string tag, input logic [31:0] w,
                           input logic exp_pre_active, input logic exp_active,
                           input logic exp_valid, input logic [31:0] exp_lane,
                           input logic exp_strobe);
    int strobes;
    strobes = 0;
    for (int i = WIDTH - 1; i > 0; i--) begin
      send_bit(w[i]);
      if (word_strobe) strobes++;
    end
    check({tag, ".pre_active"}, {31'b0, active}, {31'b0, exp_pre_active});
    check({tag, ".mid_strobes"}, strobes, 0);
    send_bit(w[0]);
    check({tag, ".active"}, {31'b0, active}, {31'b0, exp_active});
    check({tag, ".valid"}, {31'b0, valid_out}, {31'b0, exp_valid});
    check({tag, ".lane"}, lane_out, exp_lane);
    check({tag, ".strobe"}, {31'b0, word_strobe}, {31'b0, exp_strobe});
    $display("word %s %h: lane=%h valid=%0b strobe=%0b active=%0b",
             tag, w, lane_out, valid_out, word_strobe, active);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".lane"}, lane_out, 32'h0);
    check({tag, ".valid"}, {31'b0, valid_out}, 32'h0);
    check({tag, ".strobe"}, {31'b0, word_strobe}, 32'h0);
    check({tag, ".active"}, {31'b0, active}, 32'h0);
  endtask

  logic [4:0] prefix;

  initial begin
    // Reset held 3 cycles with random serial data.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_bit(1'($urandom_range(0, 1)));
      check_all_zero($sformatf("reset%0d", i));
    end
    reset = 1'b0;

    // Misaligned prefix, then four idles to lock.
    prefix = 5'b10110;
    for (int i = 4; i >= 0; i--) send_bit(prefix[i]);
    check_all_zero("prefix");
    send_word("idle1", IDLE, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    send_word("idle2", IDLE, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    send_word("idle3", IDLE, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    send_word("idle4", IDLE, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);

    // Back-to-back data words, 32 cycles apart.
    send_word("d_deadbeef", 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
    send_word("d_12345678", 32'h12345678, 1'b1, 1'b1, 1'b1, 32'h12345678, 1'b1);

    // Idle after data: valid drops, lane holds, strobe still pulses.
    send_word("d_cafef00d", 32'hCAFEF00D, 1'b1, 1'b1, 1'b1, 32'hCAFEF00D, 1'b1);
    send_word("idle_hold", IDLE, 1'b1, 1'b1, 1'b0, 32'hCAFEF00D, 1'b1);

    // One-cycle reset in the middle of ACTIVE.
    send_word("d_deadbeef2", 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
    reset = 1'b1;
    send_bit(1'b1);
    reset = 1'b0;
    check_all_zero("mid_reset");

    // Three idles interrupted by data: no lock, re-hunt, then lock on four idles.
    send_word("r_idle1", IDLE, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    send_word("r_idle2", IDLE, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    send_word("r_idle3", IDLE, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    send_word("r_data", 32'h0F0F0F0F, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    send_word("s_idle1", IDLE, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    send_word("s_idle2", IDLE, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    send_word("s_idle3", IDLE, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    send_word("s_idle4", IDLE, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    send_word("s_data", 32'h55AA33CC, 1'b1, 1'b1, 1'b1, 32'h55AA33CC, 1'b1);

    // Another reset: exactly four idles are needed to relock.
    reset = 1'b1;
    send_bit(1'b0);
    reset = 1'b0;
    check_all_zero("reset2");
    send_word("t_idle1", IDLE, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    send_word("t_idle2", IDLE, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    send_word("t_idle3", IDLE, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    send_word("t_idle4", IDLE, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    send_word("t_data", 32'h80000001, 1'b1, 1'b1, 1'b1, 32'h80000001, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
